decode: RTL and testbench
=========================

Name: decode

Overview:
- Command decoder between the UART receiver and the SDRAM write-FIFO/controller.
- Parses the received byte stream for two commands:
  - Write command (0x55): followed by a fixed-length payload that is forwarded into the write FIFO, then a write trigger is issued.
  - Read command (0xAA): issues a read trigger.
- All outputs are registered in the single clock domain.

Parameters:
- WR_CMD, 8'h55, command byte that starts a write payload
- RD_CMD, 8'hAA, command byte that requests a read
- WR_LEN, 4, number of payload bytes following WR_CMD (1..255)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  synchronous, active-high reset: 1 = reset, sampled on the clk rising edge
- rx_data  input  8  received UART byte; valid when rx_flag = 1
- rx_flag  input  1  single-cycle strobe; one strobe per received byte
- wr_trig  output  1  one-cycle pulse after a complete write payload has been pushed to the FIFO
- rd_trig  output  1  one-cycle pulse on reception of RD_CMD
- wfifo_wr_en  output  1  write-FIFO write enable, one cycle per payload byte
- wfifo_wr_data  output  8  write-FIFO data, valid while wfifo_wr_en = 1

Behaviour:
- Reset (rst_n = 1 at a clock edge):
  - All outputs go to 0; state = IDLE; byte counter = 0.
  - Reset mid-payload aborts the payload; no wr_trig is issued for it.
- A byte is "accepted" at a rising edge where rx_flag = 1 and reset is inactive. rx_flag = 0 cycles are ignored.
- States: IDLE, WR_DATA.
- IDLE:
  - Accepted byte == WR_CMD: go to WR_DATA, clear the counter. No output activity.
  - Accepted byte == RD_CMD: rd_trig = 1 for exactly the next cycle. Stay in IDLE.
  - Any other byte: ignored.
- WR_DATA:
  - Every accepted byte is payload, whatever its value (0x55 and 0xAA included, not decoded as commands).
  - On acceptance at edge N: wfifo_wr_data = rx_data and wfifo_wr_en = 1 during cycle N+1 only. Counter increments.
  - When the WR_LEN-th byte is accepted: return to IDLE and clear the counter.
  - wr_trig = 1 for exactly one cycle, the cycle immediately after that final wfifo_wr_en pulse (edge N+2), so the FIFO holds the full payload when the trigger is seen.
- wfifo_wr_data holds its last value when wfifo_wr_en = 0.
- No timeout: WR_DATA waits indefinitely for the remaining payload bytes.
- rd_trig and wr_trig are never asserted in the same cycle.
- A new command may arrive on the cycle after the last payload byte; it is handled from IDLE while the wr_trig pulse is still pending.
- Back-to-back rx_flag on consecutive cycles is supported; each strobe is treated as a new byte.

Test Plan:
- Reset held 5 cycles, no rx_flag -> all outputs 0 throughout; after release they stay 0 with no input activity.
- Write command: strobe 0x55, then 0x12, 0x34, 0x56, 0x78 (one strobe each, about 10 cycles apart):
  - Four wfifo_wr_en pulses carrying 0x12, 0x34, 0x56, 0x78 in order, each one cycle after its strobe.
  - No wr_en for the 0x55 strobe.
  - wr_trig single pulse the cycle after the 0x78 write.
- Read command: strobe 0xAA in IDLE (after the write above) -> rd_trig high exactly one cycle, the cycle after the strobe; no wfifo_wr_en.
- Payload containing command values: 0x55, then 0xAA, 0x55, 0x00, 0xFF -> all four bytes are written to the FIFO in order; no rd_trig; one wr_trig.
- Stray and robustness cases:
  - Bytes 0x12 and 0x00 in IDLE -> no outputs.
  - Reset asserted after 2 of 4 payload bytes -> no wr_trig; a following 0xAA produces rd_trig, confirming the block is back in IDLE.
- Back-to-back strobes: 0x55, 0x01, 0x02, 0x03, 0x04 on consecutive cycles -> wr_en high 4 consecutive cycles with data 01..04; wr_trig on the following cycle.

Source files
------------

// File: rtl/decode.sv
// rtl/decode.sv - UART byte-stream command decoder feeding the SDRAM write FIFO
module decode #(
  parameter logic [7:0] WR_CMD = 8'h55,
  parameter logic [7:0] RD_CMD = 8'hAA,
  parameter int         WR_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_wr_data
);

  typedef enum logic {IDLE, WR_DATA} state_t;

  localparam logic [7:0] LAST_IDX = 8'(WR_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_pend_q, wr_pend_d;
  logic       wr_trig_q, wr_trig_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_trig_q, rd_trig_d;
  logic       rd_req;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_pend_q <= 1'b0;
      wr_trig_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_trig_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_pend_q <= wr_pend_d;
      wr_trig_q <= wr_trig_d;
      rd_pend_q <= rd_pend_d;
      rd_trig_q <= rd_trig_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_pend_d = 1'b0;
    wr_trig_d = wr_pend_q;
    rd_req    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_flag) begin
          if (rx_data == WR_CMD) begin
            state_d = WR_DATA;
            cnt_d   = '0;
          end else if (rx_data == RD_CMD) begin
            rd_req = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (rx_flag) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_data;
          if (cnt_q == LAST_IDX) begin
            state_d   = IDLE;
            cnt_d     = '0;
            wr_pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A read landing on the write-trigger cycle slips one cycle so the two triggers never overlap.
    rd_pend_d = rd_req & (wr_pend_q | rd_pend_q);
    rd_trig_d = rd_pend_q | (rd_req & ~wr_pend_q & ~rd_pend_q);
  end

  assign wr_trig       = wr_trig_q;
  assign rd_trig       = rd_trig_q;
  assign wfifo_wr_en   = wr_en_q;
  assign wfifo_wr_data = wr_data_q;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed self-checking bench for decode
module tb_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       wr_trig;
  logic       rd_trig;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;

  int checks = 0;
  int errors = 0;
  int n_wr_en = 0;
  int n_rd = 0;
  int n_wt = 0;
  int n_overlap = 0;
  int base_rd, base_wt, base_en;

  decode #(.WR_CMD(8'h55), .RD_CMD(8'hAA), .WR_LEN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_flag      (rx_flag),
    .wr_trig      (wr_trig),
    .rd_trig      (rd_trig),
    .wfifo_wr_en  (wfifo_wr_en),
    .wfifo_wr_data(wfifo_wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wfifo_wr_en === 1'b1) n_wr_en++;
    if (rd_trig === 1'b1) n_rd++;
    if (wr_trig === 1'b1) n_wt++;
    if (wr_trig === 1'b1 && rd_trig === 1'b1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, wr_trig, rd_trig, wfifo_wr_en, wfifo_wr_data};
  endfunction

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, {31'd0, wr_trig | rd_trig | wfifo_wr_en}, 32'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    rx_flag = 1'b0;
    rx_data = 8'h00;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outs", outs(), 32'd0);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_outs", outs(), 32'd0);
    end

    // Write command, bytes ~10 cycles apart
    base_wt = n_wt;
    send(8'h55);
    check("wr_cmd_no_en", {31'd0, wfifo_wr_en}, 32'd0);
    idle(9, "wr_cmd_quiet");
    send(8'h12);
    check("wr_b0", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h12});
    idle(9, "wr_gap0");
    send(8'h34);
    check("wr_b1", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h34});
    idle(9, "wr_gap1");
    send(8'h56);
    check("wr_b2", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h56});
    idle(9, "wr_gap2");
    send(8'h78);
    check("wr_b3", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h78});
    check("wr_trig_early", {31'd0, wr_trig}, 32'd0);
    tick();
    check("wr_trig_pulse", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, {29'd0, 3'b100});
    check("wr_data_hold", {24'd0, wfifo_wr_data}, 32'h78);
    tick();
    check("wr_trig_end", {31'd0, wr_trig}, 32'd0);
    check("wr_trig_count", n_wt - base_wt, 32'd1);

    // Read command
    base_en = n_wr_en;
    send(8'hAA);
    check("rd_pulse", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, {29'd0, 3'b010});
    tick();
    check("rd_end", {31'd0, rd_trig}, 32'd0);
    check("rd_no_wr_en", n_wr_en - base_en, 32'd0);

    // Payload holding command values
    base_rd = n_rd;
    base_wt = n_wt;
    send(8'h55);
    tick();
    send(8'hAA);
    check("cmdval_b0", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'hAA});
    tick();
    send(8'h55);
    check("cmdval_b1", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h55});
    tick();
    send(8'h00);
    check("cmdval_b2", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h00});
    tick();
    send(8'hFF);
    check("cmdval_b3", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'hFF});
    tick();
    check("cmdval_trig", {31'd0, wr_trig}, 32'd1);
    idle(3, "cmdval_after");
    check("cmdval_no_rd", n_rd - base_rd, 32'd0);
    check("cmdval_one_wt", n_wt - base_wt, 32'd1);

    // Stray bytes in IDLE
    send(8'h12);
    check("stray_12", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, 32'd0);
    tick();
    send(8'h00);
    check("stray_00", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, 32'd0);
    idle(3, "stray_after");

    // Reset aborts a half-received payload
    base_wt = n_wt;
    send(8'h55);
    send(8'h01);
    check("abort_b0", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'h01});
    send(8'h02);
    rst_n = 1'b1;
    tick();
    check("abort_reset_outs", outs(), 32'd0);
    rst_n = 1'b0;
    idle(5, "abort_quiet");
    check("abort_no_wt", n_wt - base_wt, 32'd0);
    send(8'hAA);
    check("abort_rd_idle", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, {29'd0, 3'b010});
    tick();

    // Back-to-back strobes, then a read right behind the last payload byte
    base_rd = n_rd;
    base_wt = n_wt;
    rx_flag = 1'b1;
    rx_data = 8'h55;
    tick();
    check("b2b_cmd", {31'd0, wfifo_wr_en}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      rx_data = 8'(i);
      tick();
      check("b2b_byte", {23'd0, wfifo_wr_en, wfifo_wr_data}, {23'd0, 1'b1, 8'(i)});
      check("b2b_no_trig", {31'd0, wr_trig}, 32'd0);
    end
    rx_data = 8'hAA;
    tick();
    rx_flag = 1'b0;
    check("b2b_wr_trig", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, {29'd0, 3'b100});
    tick();
    check("b2b_rd_after", {29'd0, wr_trig, rd_trig, wfifo_wr_en}, {29'd0, 3'b010});
    idle(3, "b2b_tail");
    check("b2b_rd_count", n_rd - base_rd, 32'd1);
    check("b2b_wt_count", n_wt - base_wt, 32'd1);
    check("no_overlap", n_overlap, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
